// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
//   Sequential shift-add multiplier. One multiplier bit is consumed per clock.
//   Signed operands are handled by multiplying magnitudes and negating the
//   result at the end. Optional early termination stops iterating once the
//   remaining multiplier bits are all zero.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   request, accepted only in IDLE
//   signed_mode in   two's complement operands (only when SIGNED_EN=1)
//   a, b        in   multiplicand / multiplier, captured on accepted start
//   busy        out  high in LOAD, CALC and FIX
//   res_valid   out  product valid (DONE)
//   res_ready   in   consumer acknowledge
//   product     out  2*WIDTH-bit result, held until the next FIX
//   iter_count  out  CALC iterations used by the last operation
//
// Handshake: the result transfers on a rising edge where res_valid=1 and
// res_ready=1. While res_valid=1 and res_ready=0, product is held stable.
// res_valid never drops without that transfer (except on reset).

module seq_shift_add_mult #(
   parameter int WIDTH      = 8,
   parameter bit SIGNED_EN  = 1'b1,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         signed_mode,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   output logic                         busy,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [2*WIDTH-1:0]           product,
   output logic [$clog2(WIDTH+1)-1:0]   iter_count
);

   localparam int CW = $clog2(WIDTH+1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_CALC = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [CW-1:0] K_ONE  = 1;
   localparam logic [CW-1:0] K_LAST = WIDTH;

   logic [2:0]         state_q,   state_d;
   logic [WIDTH-1:0]   opa_q,     opa_d;     // raw a, then |a| after LOAD
   logic [WIDTH-1:0]   opb_q,     opb_d;     // raw b, then shifting |b|
   logic               mode_q,    mode_d;
   logic               neg_q,     neg_d;
   logic [2*WIDTH-1:0] p_q,       p_d;
   logic [CW-1:0]      k_q,       k_d;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic [CW-1:0]      iter_q,    iter_d;

   logic [2*WIDTH-1:0] ma_ext;

   assign ma_ext = {{WIDTH{1'b0}}, opa_q};

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      mode_d    = mode_q;
      neg_d     = neg_q;
      p_d       = p_q;
      k_d       = k_q;
      product_d = product_q;
      iter_d    = iter_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = b;
               mode_d  = signed_mode & SIGNED_EN;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // The magnitude of the most negative value still fits unsigned.
            if (mode_q) begin
               opa_d = opa_q[WIDTH-1] ? -opa_q : opa_q;
               opb_d = opb_q[WIDTH-1] ? -opb_q : opb_q;
               neg_d = opa_q[WIDTH-1] ^ opb_q[WIDTH-1];
            end else begin
               neg_d = 1'b0;
            end
            p_d     = '0;
            k_d     = '0;
            state_d = ST_CALC;
         end

         ST_CALC: begin
            if (opb_q[0]) begin
               p_d = p_q + (ma_ext << k_q);
            end
            opb_d = opb_q >> 1;
            k_d   = k_q + K_ONE;
            // Exit test uses the post-shift multiplier, so b=0 still
            // performs exactly one iteration.
            if ((k_d == K_LAST) || (EARLY_TERM && (opb_d == '0))) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
            product_d = neg_q ? -p_q : p_q;
            iter_d    = k_q;
            state_d   = ST_DONE;
         end

         ST_DONE: begin
            // A start seen here is dropped; IDLE must be reached first.
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         mode_q    <= 1'b0;
         neg_q     <= 1'b0;
         p_q       <= '0;
         k_q       <= '0;
         product_q <= '0;
         iter_q    <= '0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         mode_q    <= mode_d;
         neg_q     <= neg_d;
         p_q       <= p_d;
         k_q       <= k_d;
         product_q <= product_d;
         iter_q    <= iter_d;
      end
   end

   assign busy       = (state_q == ST_LOAD) || (state_q == ST_CALC) || (state_q == ST_FIX);
   assign res_valid  = (state_q == ST_DONE);
   assign product    = product_q;
   assign iter_count = iter_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult. Three instances share clock, reset and
// stimulus:
//   0: full      SIGNED_EN=1 EARLY_TERM=0
//   1: early     SIGNED_EN=1 EARLY_TERM=1
//   2: unsigned  SIGNED_EN=0 EARLY_TERM=0
// Expected products, latencies and iteration counts are hand-computed.

module tb_seq_shift_add_mult;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       signed_mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       res_ready;

  logic        busy_w      [3];
  logic        res_valid_w [3];
  logic [15:0] product_w   [3];
  logic [3:0]  iter_w      [3];

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  int          lat_r  [3];
  int          vcnt   [3];
  logic [15:0] prod_r [3];
  logic [3:0]  it_r   [3];
  logic        busy_r [3];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_TERM(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_w[0]), .res_valid(res_valid_w[0]),
    .res_ready(res_ready), .product(product_w[0]), .iter_count(iter_w[0]));

  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b1), .EARLY_TERM(1'b1)) u_early (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_w[1]), .res_valid(res_valid_w[1]),
    .res_ready(res_ready), .product(product_w[1]), .iter_count(iter_w[1]));

  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b0), .EARLY_TERM(1'b0)) u_uns (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_w[2]), .res_valid(res_valid_w[2]),
    .res_ready(res_ready), .product(product_w[2]), .iter_count(iter_w[2]));

  // busy and res_valid must never be high together
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy_w[i] && res_valid_w[i]) overlap++;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_op(input int i, input string tag, input logic [15:0] ep,
                          input int elat, input logic [3:0] eit);
    check_eq({tag, "_product"}, {16'h0, prod_r[i]}, {16'h0, ep});
    check_eq({tag, "_latency"}, lat_r[i], elat);
    check_eq({tag, "_iter"}, {28'h0, it_r[i]}, {28'h0, eit});
    check_eq({tag, "_valid_cycles"}, vcnt[i], 1);
    check_eq({tag, "_busy_in_done"}, {31'h0, busy_r[i]}, 32'h0);
  endtask

  // ---------------- drivers ----------------
  // One operation with res_ready held high; edge 0 is the start edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tsm);
    for (int i = 0; i < 3; i++) begin
      lat_r[i]  = -1;
      vcnt[i]   = 0;
      prod_r[i] = '0;
      it_r[i]   = '0;
      busy_r[i] = 1'b1;
    end
    @(negedge clk);
    a = ta; b = tb; signed_mode = tsm; start = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (e == 0) start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (res_valid_w[i]) begin
          vcnt[i]++;
          if (lat_r[i] < 0) begin
            lat_r[i]  = e;
            prod_r[i] = product_w[i];
            it_r[i]   = iter_w[i];
            busy_r[i] = busy_w[i];
          end
        end
      end
    end
  endtask

  task automatic wait_valid0(input string tag, input int bound);
    int waited;
    waited = 0;
    while (!res_valid_w[0] && waited < bound) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq({tag, "_valid_seen"}, {31'h0, res_valid_w[0]}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0;
    a = '0; b = '0; res_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",    {31'h0, busy_w[0]},      32'h0);
    check_eq("rst_valid",   {31'h0, res_valid_w[0]}, 32'h0);
    check_eq("rst_product", {16'h0, product_w[0]},   32'h0);
    check_eq("rst_iter",    {28'h0, iter_w[0]},      32'h0);
    @(negedge clk); rst_n = 1'b1;

    // unsigned 13*11
    run_op(8'd13, 8'd11, 1'b0);
    check_op(0, "t1_full",  16'd143, 10, 4'd8);
    check_op(1, "t1_early", 16'd143, 6,  4'd4);
    check_op(2, "t1_uns",   16'd143, 10, 4'd8);

    // signed -7*6
    run_op(8'hF9, 8'h06, 1'b1);
    check_op(0, "t2_full",  16'hFFD6, 10, 4'd8);
    check_op(1, "t2_early", 16'hFFD6, 5,  4'd3);
    check_op(2, "t2_uns",   16'd1494, 10, 4'd8);

    // signed (-128)*(-128)
    run_op(8'h80, 8'h80, 1'b1);
    check_op(0, "t2m_full",  16'h4000, 10, 4'd8);
    check_op(1, "t2m_early", 16'h4000, 10, 4'd8);
    check_op(2, "t2m_uns",   16'h4000, 10, 4'd8);

    // same operands, unsigned mode
    run_op(8'hF9, 8'h06, 1'b0);
    check_op(0, "t2u_full",  16'd1494, 10, 4'd8);
    check_op(1, "t2u_early", 16'd1494, 5,  4'd3);
    check_op(2, "t2u_uns",   16'd1494, 10, 4'd8);

    // SIGNED_EN=0 ignores signed_mode
    run_op(8'hFF, 8'h02, 1'b1);
    check_op(0, "t6_full",  16'hFFFE, 10, 4'd8);
    check_op(1, "t6_early", 16'hFFFE, 4,  4'd2);
    check_op(2, "t6_uns",   16'd510,  10, 4'd8);

    // early termination
    run_op(8'd200, 8'd3, 1'b0);
    check_op(1, "t3_early", 16'd600, 4,  4'd2);
    check_op(0, "t3_full",  16'd600, 10, 4'd8);
    run_op(8'd200, 8'd0, 1'b0);
    check_op(1, "t3z_early", 16'd0, 3,  4'd1);
    check_op(0, "t3z_full",  16'd0, 10, 4'd8);

    // backpressure, start ignored in CALC and DONE
    @(negedge clk);
    res_ready = 1'b0; start = 1'b1; a = 8'd13; b = 8'd11; signed_mode = 1'b0;
    @(posedge clk);                      // edge 0
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);           // edges 1, 2
    @(negedge clk); start = 1'b1; a = 8'd2; b = 8'd2;
    @(posedge clk);                      // edge 3, unit in CALC
    @(negedge clk); start = 1'b0;
    wait_valid0("t4_first", 20);
    check_eq("t4_product", {16'h0, product_w[0]}, 32'd143);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = (c == 2); a = 8'd7; b = 8'd7;
      @(posedge clk); #1;
      check_eq("t4_hold_valid",   {31'h0, res_valid_w[0]}, 32'h1);
      check_eq("t4_hold_product", {16'h0, product_w[0]},   32'd143);
    end
    @(negedge clk);
    res_ready = 1'b1; start = 1'b1; a = 8'd3; b = 8'd3;
    @(posedge clk); #1;
    check_eq("t4_valid_drop",  {31'h0, res_valid_w[0]}, 32'h0);
    check_eq("t4_start_ignored", {31'h0, busy_w[0]},    32'h0);
    @(posedge clk); #1;
    check_eq("t4_next_accept", {31'h0, busy_w[0]},      32'h1);
    @(negedge clk); start = 1'b0;
    wait_valid0("t4_second", 20);
    check_eq("t4_second_product", {16'h0, product_w[0]}, 32'd9);
    check_eq("t4_second_iter",    {28'h0, iter_w[0]},    32'd8);
    repeat (4) @(posedge clk);

    // reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; a = 8'd13; b = 8'd11; signed_mode = 1'b0;
    @(posedge clk);                      // edge 0
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);           // LOAD, iterations 1 and 2
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("t5_busy",    {31'h0, busy_w[0]},      32'h0);
    check_eq("t5_valid",   {31'h0, res_valid_w[0]}, 32'h0);
    check_eq("t5_product", {16'h0, product_w[0]},   32'h0);
    check_eq("t5_iter",    {28'h0, iter_w[0]},      32'h0);
    check_eq("t5_early_busy", {31'h0, busy_w[1]},   32'h0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (res_valid_w[0] || res_valid_w[1] || res_valid_w[2]) seen++;
    end
    check_eq("t5_no_aborted_result", seen, 0);
    run_op(8'd5, 8'd5, 1'b0);
    check_op(0, "t5_full",  16'd25, 10, 4'd8);
    check_op(1, "t5_early", 16'd25, 5,  4'd3);
    check_op(2, "t5_uns",   16'd25, 10, 4'd8);

    check_eq("busy_valid_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
Parametrised sequential multiplier that replaces the fixed repeated-addition datapath and controller with a single block. It uses a shift-add iteration, one multiplier bit per clock. It supports an optional signed mode and an optional early-termination mode, and returns the result through a valid/ready handshake. It sits between a requesting unit (start/operands) and a consumer that acknowledges the product.

Parameters:
WIDTH, 8, operand width in bits (must be >= 2); product is 2*WIDTH bits.
SIGNED_EN, 1, 1 = honour the signed_mode input; 0 = always unsigned (signed_mode ignored).
EARLY_TERM, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always WIDTH iterations.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst_n  in  1  synchronous, active-low reset (sampled on rising clk).
start  in  1  request; accepted only in IDLE.
signed_mode  in  1  operands are two's complement (effective only if SIGNED_EN=1); captured with start.
a  in  WIDTH  multiplicand; captured on accepted start.
b  in  WIDTH  multiplier; captured on accepted start.
busy  out  1  high in LOAD, CALC and FIX.
res_valid  out  1  product valid; high in DONE.
res_ready  in  1  consumer acknowledge.
product  out  2*WIDTH  result; stable while res_valid=1.
iter_count  out  $clog2(WIDTH+1)  number of CALC iterations used by the last operation.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, busy=0, res_valid=0, product=0, iter_count=0, internal accumulator, counters and flags cleared.
  - Applies from any state, including mid-operation. No result is emitted for an aborted operation.
- FSM states: IDLE, LOAD, CALC, FIX, DONE.
- IDLE:
  - start=1 captures a, b and mode (mode = signed_mode & SIGNED_EN), then goes to LOAD.
  - start is ignored in every other state. It is not queued.
- LOAD (1 cycle):
  - If mode=1: ma=|a|, mb=|b| as WIDTH-bit unsigned; neg = a[MSB]^b[MSB].
  - If mode=0: ma=a, mb=b, neg=0.
  - Accumulator P (2*WIDTH bits) cleared, iteration count k cleared. Goes to CALC.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH unsigned bits; no overflow.
- CALC (one iteration per cycle):
  - If mb[0]=1: P = P + (ma << k), zero-extended to 2*WIDTH.
  - Then mb = mb >> 1 and k = k+1.
  - Exit to FIX when k reaches WIDTH, or (EARLY_TERM=1 and the shifted mb == 0).
  - At least 1 iteration is always performed (b=0 gives 1 iteration with EARLY_TERM=1).
- FIX (1 cycle):
  - product = neg ? (~P+1) : P; iter_count = k; res_valid set to 1. Goes to DONE.
  - Zero product with neg=1 yields 0; no special case is needed.
- DONE:
  - Hold product and res_valid=1 until res_ready=1 is sampled.
  - On that edge res_valid is cleared and the FSM returns to IDLE.
  - A start presented in the same cycle is ignored. The earliest new accept is the following edge.
  - product keeps its last value in IDLE.
- Latency with EARLY_TERM=0: start is sampled at edge 0; res_valid is high after edge WIDTH+2.
- Latency with EARLY_TERM=1: res_valid is high after edge n+2, where n = max(1, index of highest set bit of mb +1).
- busy and res_valid are never high simultaneously.
- Arithmetic:
  - Unsigned product is exact in 2*WIDTH bits.
  - Signed product is exact as a 2*WIDTH two's-complement value, including (-2^(WIDTH-1))^2.

Test Plan:
1. WIDTH=8, EARLY_TERM=0, unsigned, a=13, b=11, res_ready=1 -> product=16'd143, res_valid high after edge 10 from start, iter_count=8, busy low in DONE.
2. Signed, a=8'hF9 (-7), b=8'h06 -> product=16'hFFD6 (-42). Also a=b=8'h80 -> product=16'h4000 (16384). Same operands unsigned: 8'hF9*6 -> 16'd1494.
3. EARLY_TERM=1, unsigned, a=200, b=3 -> product=16'd600, iter_count=2, res_valid after edge 4. Also b=0 -> product=0, iter_count=1.
4. Backpressure: hold res_ready=0 for 5 cycles after res_valid -> product/res_valid stable. start pulsed during DONE and during CALC is ignored (no second result). After res_ready=1, res_valid drops next edge and a new start is accepted one edge later.
5. Reset mid-CALC: rst_n=0 for one edge at iteration 3 -> IDLE, busy=0, res_valid=0, product=0, iter_count=0. A subsequent 5*5 returns 16'd25 normally.
6. SIGNED_EN=0 with signed_mode=1, a=8'hFF, b=8'h02 -> product=16'd510 (unsigned interpretation).
